// File: rtl/crt_2011_2048_to_x_pkg.sv
// Shared constants and types for the {2011, 2048} residue-to-binary converter.
//   M_2011            : the odd modulus
//   INV_2048_MOD_2011 : (2048)^-1 mod 2011, i.e. 37^-1 mod 2011
//   W_RES / W_X       : residue width / reconstructed value width
//   state_t           : converter FSM states
package mod_2011_pkg;

  localparam logic [10:0] M_2011            = 11'd2011;
  localparam logic [9:0]  INV_2048_MOD_2011 = 10'd924;
  localparam int unsigned W_RES             = 11;
  localparam int unsigned W_X               = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/crt_2011_2048_to_x_if.sv
// Handshake bundle between a residue-pair producer/result consumer (master)
// and the converter (slave).
//   in_valid/in_ready/r_a/r_b : residue pair input handshake
//   out_valid/out_ready/x/err : reconstructed value output handshake
interface crt_2011_2048_to_x_if;
  import mod_2011_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W_RES-1:0] r_a;
  logic [W_RES-1:0] r_b;
  logic             out_valid;
  logic             out_ready;
  logic [W_X-1:0]   x;
  logic             err;

  modport master (
    output in_valid, r_a, r_b, out_ready,
    input  in_ready, out_valid, x, err
  );

  modport slave (
    input  in_valid, r_a, r_b, out_ready,
    output in_ready, out_valid, x, err
  );

endinterface

// File: rtl/crt_2011_2048_to_x_dbl_add.sv
// One MSB-first double-and-add step of a modular multiply:
//   acc_next_o = (2*acc_i + (bit_i ? d_i : 0)) mod 2011
// Ports:
//   acc_i      : running accumulator, < 2011 for legal operands
//   d_i        : multiplicand, < 2011 for legal operands
//   bit_i      : current multiplier bit
//   acc_next_o : updated accumulator
module mod_2011_dbl_add
  import mod_2011_pkg::*;
(
  input  logic [10:0] acc_i,
  input  logic [10:0] d_i,
  input  logic        bit_i,
  output logic [10:0] acc_next_o
);

  logic [11:0] dbl;
  logic [11:0] dbl_m;
  logic [11:0] sum;

  always_comb begin
    dbl        = {acc_i, 1'b0};
    dbl_m      = (dbl >= 12'(M_2011)) ? dbl - 12'(M_2011) : dbl;
    sum        = dbl_m + (bit_i ? {1'b0, d_i} : 12'd0);
    acc_next_o = 11'((sum >= 12'(M_2011)) ? sum - 12'(M_2011) : sum);
  end

endmodule

// File: rtl/crt_2011_2048_to_x.sv
// Sequential residue-to-binary converter for moduli {2011, 2048}.
// Rebuilds X in [0, 2011*2048) from (X mod 2011, X mod 2048) via mixed-radix
// CRT: X = r_b + 2048*t, t = ((r_a - r_b mod 2011) mod 2011) * 924 mod 2011.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   io    : slave side of the handshake bundle (see crt_2011_2048_to_x_if)
module crt_2011_2048_to_x
  import mod_2011_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  crt_2011_2048_to_x_if.slave   io
);

  state_t           state_q, state_d;
  logic [W_RES-1:0] ra_q, ra_d;
  logic [W_RES-1:0] rb_q, rb_d;
  logic             err_q, err_d;
  logic [10:0]      d_q, d_d;
  logic [10:0]      acc_q, acc_d;
  logic [3:0]       idx_q, idx_d;
  logic [W_X-1:0]   x_q, x_d;

  logic [10:0]        rb_red;
  logic signed [11:0] diff;
  logic [10:0]        d_prep;
  logic [9:0]         inv;
  logic               inv_bit;
  logic [10:0]        acc_nxt;

  // PREP datapath: d = (r_a - r_b mod 2011) mod 2011. A negative diff lies in
  // -2010..-1, so adding 2011 to its low 11 bits (mod 2048) yields the residue.
  always_comb begin
    rb_red = (rb_q >= M_2011) ? rb_q - M_2011 : rb_q;
    diff   = $signed({1'b0, ra_q}) - $signed({1'b0, rb_red});
    d_prep = diff[11] ? diff[10:0] + M_2011 : diff[10:0];
  end

  assign inv     = INV_2048_MOD_2011;
  assign inv_bit = inv[idx_q];

  mod_2011_dbl_add u_dbl_add (
    .acc_i      (acc_q),
    .d_i        (d_q),
    .bit_i      (inv_bit),
    .acc_next_o (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    err_d   = err_q;
    d_d     = d_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          ra_d    = io.r_a;
          rb_d    = io.r_b;
          err_d   = (io.r_a >= M_2011);
          state_d = PREP;
        end
      end
      PREP: begin
        d_d     = d_prep;
        acc_d   = '0;
        idx_d   = 4'd9;
        state_d = MUL;
      end
      MUL: begin
        acc_d = acc_nxt;
        idx_d = idx_q - 4'd1;
        if (idx_q == 4'd0) begin
          // t < 2011, so the final X is a plain concatenation with r_b.
          x_d     = err_q ? '0 : {acc_nxt, rb_q};
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      err_q   <= 1'b0;
      d_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      err_q   <= err_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.x         = x_q;
  assign io.err       = err_q;

endmodule

// File: tb/tb_crt_2011_2048_to_x.sv
// Self-checking bench for crt_2011_2048_to_x: directed vectors, backpressure,
// illegal residue, mid-operation reset and a randomized round-trip sweep.
module tb_crt_2011_2048_to_x;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  crt_2011_2048_to_x_if bus ();

  crt_2011_2048_to_x dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: search the 2011 candidates X = rb + 2048*k for the one whose
  // residue mod 2011 equals ra. Illegal ra gives err=1, x=0.
  function automatic void ref_crt(input int ra, input int rb, output int xo, output bit eo);
    xo = 0;
    eo = (ra >= 2011);
    if (!eo) begin
      for (int k = 0; k < 2011; k++) begin
        if (((rb + 2048 * k) % 2011) == ra) begin
          xo = rb + 2048 * k;
          break;
        end
      end
    end
  endfunction

  task automatic run_txn(input string tag, input int ra, input int rb,
                         input int exp_x, input bit exp_err,
                         input int hold, input bit poke);
    int lat;
    lat = 0;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.r_a      = 11'(ra);
    bus.r_b      = 11'(rb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.r_a      = 11'($urandom);
    bus.r_b      = 11'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'd11);
    check({tag, ".x"}, 32'(bus.x), 32'(exp_x));
    check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.r_a      = 11'($urandom);
        bus.r_b      = 11'($urandom);
      end
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_x"}, 32'(bus.x), 32'(exp_x));
      check({tag, ".hold_err"}, 32'(bus.err), 32'(exp_err));
      if (poke) check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  xv, xr;
    int  ra, rb;
    bit  er;
    bit  seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.r_a       = '0;
    bus.r_b       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(bus.in_ready),  32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.x",         32'(bus.x),         32'd0);
    check("rst.err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle does nothing
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ordy.out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_ordy.in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;

    run_txn("zero",    0,    0,    0,       1'b0, 0, 1'b0);
    run_txn("r37",     37,   0,    2048,    1'b0, 0, 1'b0);
    run_txn("v12345",  279,  57,   12345,   1'b0, 0, 1'b0);
    run_txn("max",     2010, 2047, 4118527, 1'b0, 0, 1'b0);
    run_txn("rbhigh",  36,   2047, 2047,    1'b0, 0, 1'b0);
    run_txn("bp",      279,  57,   12345,   1'b0, 20, 1'b1);
    run_txn("illegal", 2011, 5,    0,       1'b1, 2, 1'b0);

    // Reset pulse during MUL cycle 5
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.r_a      = 11'd100;
    bus.r_b      = 11'd200;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst.x",         32'(bus.x),         32'd0);
    check("midrst.err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst.no_pulse", 32'(seen), 32'd0);
    run_txn("post_rst", 37, 0, 2048, 1'b0, 0, 1'b0);

    // Randomized round trip
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(9, 0) == 0) begin
        ra = 2011 + int'($urandom_range(36, 0));
        rb = int'($urandom_range(2047, 0));
        ref_crt(ra, rb, xr, er);
        run_txn("rnd_err", ra, rb, xr, er, int'($urandom_range(2, 0)), 1'b0);
      end else begin
        xv = int'($urandom_range(4118527, 0));
        ra = xv % 2011;
        rb = xv % 2048;
        ref_crt(ra, rb, xr, er);
        check("rnd.model", 32'(xr), 32'(xv));
        run_txn("rnd", ra, rb, xv, 1'b0, int'($urandom_range(2, 0)), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
